ram_loader: RTL and testbench



---
 rtl/ram_loader.sv | 133 +++++++++++++
 tb/tb_ram_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: UART byte stream to 16-bit RAM program loader; RAM_LOADER_CHECKSUM_EN adds an XOR trailer check
module ram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 8192,
  parameter int         ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic [0:15]       ram_data,
  output logic              ram_load,
  output logic [0:ADDR_W-1] ram_address,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam int CW = ADDR_W + 1;
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, BYTE_HI, BYTE_LO, WRITE,
`ifdef RAM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHK;
  logic [7:0] chk_q, chk_d;
`else
  localparam state_t LAST = DONE;
`endif
  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [CW-1:0]     wc_q, wc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       data_d;
  logic [ADDR_W-1:0] addr_d;
  logic              load_d, xfer;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    hi_d    = hi_q;
    data_d  = ram_data;
    addr_d  = ram_address;
    load_d  = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    xfer    = rx_valid && rx_ready;
    case (state_q)
      IDLE:    if (xfer && rx_data == SYNC_BYTE) state_d = CNT_HI;
      CNT_HI:  if (xfer) begin
        cnt_d   = {rx_data, 8'h00};
        state_d = CNT_LO;
      end
      CNT_LO:  if (xfer) begin
        cnt_d   = {cnt_q[15:8], rx_data};
        wc_d    = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
        chk_d   = '0;
`endif
        state_d = (cnt_d == '0 || cnt_d > MAX_N) ? ERR : BYTE_HI;
      end
      BYTE_HI: if (xfer) begin
        hi_d    = rx_data;
`ifdef RAM_LOADER_CHECKSUM_EN
        chk_d   = chk_q ^ rx_data;
`endif
        state_d = BYTE_LO;
      end
      BYTE_LO: if (xfer) begin
        data_d  = {hi_q, rx_data};
        addr_d  = wc_q[ADDR_W-1:0];
        load_d  = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
        chk_d   = chk_q ^ rx_data;
`endif
        state_d = WRITE;
      end
      WRITE: begin
        wc_d    = wc_q + CW'(1);
        state_d = (16'(wc_q) + 16'd1 == cnt_q) ? LAST : BYTE_HI;
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CHK:     if (xfer) state_d = (rx_data == chk_q) ? DONE : ERR;
`endif
      DONE, ERR: if (start) begin
        state_d = IDLE;
        wc_d    = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wc_q        <= '0;
      hi_q        <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
      ram_data    <= '0;
      ram_address <= '0;
      ram_load    <= 1'b0;
      rx_ready    <= 1'b1;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wc_q        <= wc_d;
      hi_q        <= hi_d;
`ifdef RAM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
      ram_data    <= data_d;
      ram_address <= addr_d;
      ram_load    <= load_d;
      rx_ready    <= !(state_d inside {WRITE, DONE, ERR});
      cpu_hold    <= state_d != DONE;
      done        <= state_d == DONE;
      error       <= state_d == ERR;
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized frames vs a frame-parsing reference model, writes checked by a scoreboard monitor
module tb_ram_loader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, start = 1'b0;
  logic        rx_ready, ram_load, cpu_hold, done, error;
  logic [0:15] ram_data;
  logic [0:12] ram_address;
  int          checks = 0, errors = 0;
  int          cyc = 0, last_load = -1;
  bit          spacing = 1'b0;
  logic [28:0] exp_q[$];
  logic [28:0] mon_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ram_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start(start), .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && ram_load) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", ram_address, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(ram_address), 32'(mon_e[28:16]));
        chk("write_data", 32'(ram_data), 32'(mon_e[15:0]));
      end
      if (spacing && last_load >= 0) chk("load_spacing", 32'(cyc - last_load), 32'd3);
      last_load = cyc;
    end
  end
  // Reference: parse the byte list as a frame; returns 0 incomplete, 1 done, 2 rejected.
  task automatic model(input logic [7:0] b[$], output int outc);
    int i = 0;
    int n;
    logic [7:0] x = '0;
    outc = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    i++;
    if (i + 1 >= b.size()) return;
    n = {b[i], b[i+1]};
    i += 2;
    if (n == 0 || n > 8192) begin
      outc = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (i + 1 >= b.size()) return;
      exp_q.push_back({13'(w), b[i], b[i+1]});
      x ^= b[i] ^ b[i+1];
      i += 2;
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    if (i >= b.size()) return;
    outc = (b[i] == x) ? 1 : 2;
`else
    outc = 1;
`endif
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready) begin
      @(negedge clk);
      if (++t > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: rx_ready stayed 0 for byte %0h", b);
        break;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic finish_check(input int outc);
    int t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'(outc == 1));
    chk("error", 32'(error), 32'(outc == 2));
    chk("cpu_hold", 32'(cpu_hold), 32'(outc != 1));
    chk("rx_ready_end", 32'(rx_ready), 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_error", 32'(error), 32'd0);
    chk("rearm_hold", 32'(cpu_hold), 32'd1);
    chk("rearm_ready", 32'(rx_ready), 32'd1);
  endtask
  task automatic run(input logic [7:0] b[$], input int gapmax);
    int outc;
    model(b, outc);
    foreach (b[i]) begin
      repeat (gapmax > 0 ? $urandom_range(gapmax, 0) : 0) @(negedge clk);
      send(b[i]);
    end
    finish_check(outc);
  endtask
  task automatic check_reset();
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_load", 32'(ram_load), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
  endtask
  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    int n;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);
    q = {8'hA5, 8'h00, 8'h03, 8'h00, 8'h03, 8'hE0, 8'h00, 8'hFC, 8'h10};
`ifdef RAM_LOADER_CHECKSUM_EN
    q.push_back(8'h0F);
`endif
    run(q, 2);
    q = {8'h3C, 8'h7F, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
`ifdef RAM_LOADER_CHECKSUM_EN
    q.push_back(8'h26);
`endif
    run(q, 0);
    q = {8'hA5, 8'h00, 8'h00};
    run(q, 1);
    q = {8'hA5, 8'h20, 8'h01};
    run(q, 1);
    q = {8'hA5, 8'h00, 8'h02, 8'hAB};
    foreach (q[i]) send(q[i]);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);
    q = {8'hA5, 8'h00, 8'h01, 8'h55, 8'hAA};
`ifdef RAM_LOADER_CHECKSUM_EN
    q.push_back(8'hFF);
`endif
    run(q, 1);
`ifdef RAM_LOADER_CHECKSUM_EN
    q = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    run(q, 0);
    q = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    run(q, 0);
`endif
    for (int f = 0; f < 24; f++) begin
      q.delete();
      repeat ($urandom_range(3, 0)) q.push_back(8'($urandom_range(8'hA4, 0)));
      q.push_back(8'hA5);
      n = ($urandom_range(5, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(65535, 8193)))
                                      : int'($urandom_range(8, 1));
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      if (n >= 1 && n <= 8192) begin
        x = '0;
        for (int w = 0; w < 2 * n; w++) begin
          q.push_back(8'($urandom));
          x ^= q[q.size() - 1];
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        q.push_back(($urandom_range(3, 0) == 0) ? x ^ 8'($urandom_range(255, 1)) : x);
`endif
      end
      run(q, 3);
    end
    q = {8'hA5, 8'h20, 8'h00};
    x = '0;
    for (int w = 0; w < 2 * 8192; w++) begin
      q.push_back(8'($urandom));
      x ^= q[q.size() - 1];
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    q.push_back(x);
`endif
    last_load = -1;
    spacing = 1'b1;
    run(q, 0);
    spacing = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
